// File: rtl/restoring_divider.sv
// Sequential restoring (shift-subtract) divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional two's-complement mode enabled by defining SIGNED_DIV_EN.
module restoring_divider #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, FINISH} state_t;

  localparam int unsigned CW = $clog2(N + 1);

  state_t           state;
  logic [2*N-1:0]   dvd;
  logic [N-1:0]     dvs;
  logic [N-1:0]     rem_r;
  logic [N-1:0]     quo_r;
  logic [CW-1:0]    count;
  logic             err_zero;
  logic             err_ovf;

  logic [N:0]       shifted;
  logic [N:0]       trial;
  logic [2*N-1:0]   dvd_mag;
  logic [N-1:0]     dvs_mag;

  // Trial subtraction at N+1 bits keeps the bit shifted out of R.
  assign shifted = {rem_r, quo_r[N-1]};
  assign trial   = shifted - {1'b0, dvs};

`ifdef SIGNED_DIV_EN
  localparam logic [N-1:0] MIN_MAG = {1'b1, {(N-1){1'b0}}};

  logic q_neg;
  logic r_neg;
  logic ovf_sign;

  assign dvd_mag  = dvd[2*N-1] ? ('0 - dvd) : dvd;
  assign dvs_mag  = dvs[N-1]   ? ('0 - dvs) : dvs;
  // Magnitude 2^(N-1) is representable only when the result is negative.
  assign ovf_sign = quo_r[N-1] && (!q_neg || (quo_r != MIN_MAG));
`else
  assign dvd_mag = dvd;
  assign dvs_mag = dvs;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      count       <= '0;
      err_zero    <= 1'b0;
      err_ovf     <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            state       <= CHECK;
          end
        end

        CHECK: begin
          err_zero <= 1'b0;
          err_ovf  <= 1'b0;
`ifdef SIGNED_DIV_EN
          q_neg    <= dvd[2*N-1] ^ dvs[N-1];
          r_neg    <= dvd[2*N-1];
`endif
          if (dvs == '0) begin
            err_zero <= 1'b1;
            state    <= FINISH;
          end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
            err_ovf <= 1'b1;
            state   <= FINISH;
          end else begin
            rem_r <= dvd_mag[2*N-1:N];
            quo_r <= dvd_mag[N-1:0];
            dvs   <= dvs_mag;
            count <= CW'(N);
            state <= ITER;
          end
        end

        ITER: begin
          if (!trial[N]) begin
            rem_r <= trial[N-1:0];
            quo_r <= {quo_r[N-2:0], 1'b1};
          end else begin
            rem_r <= shifted[N-1:0];
            quo_r <= {quo_r[N-2:0], 1'b0};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FINISH;
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (err_zero) begin
            quotient    <= '1;
            remainder   <= dvd[N-1:0];
            div_by_zero <= 1'b1;
          end else if (err_ovf) begin
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
`ifdef SIGNED_DIV_EN
            if (ovf_sign) begin
              quotient  <= '0;
              remainder <= '0;
              overflow  <= 1'b1;
            end else begin
              quotient  <= q_neg ? ('0 - quo_r) : quo_r;
              remainder <= r_neg ? ('0 - rem_r) : rem_r;
            end
`else
            quotient  <= quo_r;
            remainder <= rem_r;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed plan cases plus random operands
// checked against an arithmetic reference model (unsigned, or signed when SIGNED_DIV_EN is defined).
module tb_restoring_divider;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } res_t;

  restoring_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t m;
`ifdef SIGNED_DIV_EN
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
`else
    int unsigned ua, ub, q, r;
    ua = a;
    ub = b;
`endif
    m = '{q: 8'h00, r: 8'h00, dz: 1'b0, ov: 1'b0};
    if (b == 8'h00) begin
      m.q  = 8'hFF;
      m.r  = a[7:0];
      m.dz = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      q = sa / sb;
      r = sa % sb;
      if (q > 127 || q < -128) m.ov = 1'b1;
`else
      q = ua / ub;
      r = ua % ub;
      if (q > 255) m.ov = 1'b1;
`endif
      if (!m.ov) begin
        m.q = q[7:0];
        m.r = r[7:0];
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges (sampled #1 after) until done, starting from a given edge count.
  task automatic wait_done(input int first, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = first;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
    res_t m;
    m = model(a, b);
    check({tag, "_q"},  32'(quotient),    32'(m.q));
    check({tag, "_r"},  32'(remainder),   32'(m.r));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(m.dz));
    check({tag, "_ov"}, 32'(overflow),    32'(m.ov));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    res_t m;
    int   edges;
    m = model(a, b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(0, edges);
    check({tag, "_lat"}, 32'(edges), (m.dz || m.ov) ? 32'd2 : 32'(N + 2));
    check_result(tag, a, b);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   edges;
    bit   seen;
    logic [7:0]  rb;
    logic [15:0] ra;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q",    32'(quotient), 32'd0);
    check("rst_r",    32'(remainder), 32'd0);
    check("rst_dz",   32'(div_by_zero), 32'd0);
    check("rst_ov",   32'(overflow), 32'd0);
    reset = 1'b0;

`ifdef SIGNED_DIV_EN
    run_op("s_neg", 16'hFF9C, 8'h07);
    check("s_neg_q_const", 32'(quotient), 32'hF2);
    check("s_neg_r_const", 32'(remainder), 32'hFE);
    run_op("s_pos_ovf", 16'h0080, 8'h01);
    check("s_pos_ovf_const", 32'(overflow), 32'd1);
    run_op("s_min", 16'hFF80, 8'h01);
    check("s_min_q_const", 32'(quotient), 32'h80);
    check("s_min_ov_const", 32'(overflow), 32'd0);
    run_op("s_zero", 16'h1234, 8'h00);
`else
    run_op("basic", 16'h03E8, 8'h07);
    check("basic_q_const", 32'(quotient), 32'h8E);
    check("basic_r_const", 32'(remainder), 32'h06);
    run_op("edge_max", 16'hFEFF, 8'hFF);
    check("edge_max_q_const", 32'(quotient), 32'hFF);
    check("edge_max_r_const", 32'(remainder), 32'hFE);
    run_op("edge_ovf", 16'hFF00, 8'hFF);
    check("edge_ovf_const", 32'(overflow), 32'd1);
    run_op("zero", 16'h1234, 8'h00);
    check("zero_q_const", 32'(quotient), 32'hFF);
    check("zero_r_const", 32'(remainder), 32'h34);
`endif

    // Second start during ITER must be ignored.
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    dividend = 16'h0064;
    divisor  = 8'h0A;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, edges);
    check("ign_lat", 32'(edges), 32'(N + 2));
    check_result("ign", 16'h03E8, 8'h07);
    @(posedge clk); #1;

    // Start held high through done: second op accepted on the done cycle.
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = 16'h0BB8;
    divisor  = 8'h0D;
    wait_done(0, edges);
    check("b2b1_lat", 32'(edges), 32'(N + 2));
    check_result("b2b1", 16'h03E8, 8'h07);
    wait_done(0, edges);
    start = 1'b0;
    check("b2b2_lat", 32'(edges), 32'(N + 3));
    check_result("b2b2", 16'h0BB8, 8'h0D);
    @(posedge clk); #1;

    // Reset during the 4th ITER cycle aborts with everything cleared.
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q",    32'(quotient), 32'd0);
    check("abort_r",    32'(remainder), 32'd0);
    check("abort_dz",   32'(div_by_zero), 32'd0);
    check("abort_ov",   32'(overflow), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    run_op("after_abort", 16'h0064, 8'h0A);
`ifndef SIGNED_DIV_EN
    check("after_abort_q_const", 32'(quotient), 32'h0A);
    check("after_abort_r_const", 32'(remainder), 32'h00);
`endif

    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       rb = 8'h00;
        1, 2:    ra = 16'($urandom);
        default: ra = (rb == 8'h00) ? 16'($urandom)
                                    : {8'($urandom_range(0, int'(rb) - 1)), 8'($urandom)};
      endcase
      if (rb == 8'h00) ra = 16'($urandom);
      run_op("rand", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential shift-subtract divider; the inverse of the team's shift-add Booth multiplier.
- Takes a 2N-bit dividend (for example a product) and an N-bit divisor. Returns an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Has a start/busy/done handshake so it can sit beside the multiplier in the same datapath and clock domain.

Parameters:
N, 8, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  2N  dividend, captured on accepted start
divisor  input  N  divisor, captured on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  N  registered quotient, held until next accepted start
remainder  output  N  registered remainder, held until next accepted start
div_by_zero  output  1  registered error flag, updated with done
overflow  output  1  registered error flag, updated with done

Behaviour:
- Reset: reset is synchronous, active-high. state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, internal registers=0. Reset asserted mid-operation aborts the operation: no done pulse, all outputs cleared.
- States: IDLE, CHECK, ITER, FINISH.
- IDLE: on start=1, capture dividend and divisor, and clear div_by_zero/overflow. Next state is CHECK. The quotient/remainder outputs keep their old values until FINISH.
- CHECK:
  - divisor==0 -> FINISH with the zero-divide error.
  - dividend[2N-1:N] >= divisor -> FINISH with the overflow error.
  - Otherwise load R=dividend[2N-1:N], Q=dividend[N-1:0], count=N, and go to ITER.
- ITER, one iteration per cycle:
  - Shift {R,Q} left one bit.
  - Form trial = {R_shifted (N+1 bits)} - {1'b0,divisor}, computed at N+1 bits so no carry is lost.
  - If trial is non-negative: R=trial[N-1:0] and Q[0]=1. Else R is unchanged (restored) and Q[0]=0.
  - Decrement count. The iteration that brings count to 0 moves to FINISH.
- FINISH: register the outputs, set done=1 for the following cycle only, and return to IDLE.
  - Normal: quotient=Q, remainder=R.
  - Zero divide: quotient={N{1'b1}}, remainder=dividend[N-1:0], div_by_zero=1.
  - Overflow: quotient=0, remainder=0, overflow=1.
- Latency, with the accepting start edge as edge 0:
  - Normal: done high in the cycle after edge N+2, i.e. N+3 cycles from request to done for N=8.
  - Error paths: done high after edge 2.
- Handshake:
  - start is ignored while busy=1.
  - start held high in IDLE in the same cycle that done is high is accepted; back-to-back operations are allowed.
  - done and busy are never both high.
- Overflow and div_by_zero are mutually exclusive; zero divide takes priority.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - CHECK takes magnitudes (|dividend| at 2N bits, |divisor| at N bits) and runs the unsigned core on them.
  - FINISH negates the quotient if the operand signs differ and negates the remainder if the dividend is negative (truncation toward zero). This adds no extra cycles.
  - overflow is also set when the quotient magnitude exceeds 2^(N-1)-1 for a positive result or 2^(N-1) for a negative result.
  - The overflow check in CHECK uses the magnitudes.
- Undefined: purely unsigned; no sign logic is synthesized.

Test Plan:
- Unsigned normal: dividend=16'h03E8, divisor=8'h07, start for 1 cycle -> busy for 10 cycles, done after edge 10, quotient=8'h8E, remainder=8'h06, flags 0.
- Boundary: 16'hFEFF / 8'hFF -> quotient=8'hFF, remainder=8'hFE, overflow=0. Then 16'hFF00 / 8'hFF -> overflow=1, quotient=0, remainder=0, done after edge 2.
- Zero divide: 16'h1234 / 8'h00 -> div_by_zero=1, overflow=0, quotient=8'hFF, remainder=8'h34, done after edge 2.
- Handshake: a second start pulse with different operands during ITER -> ignored; the first result is unchanged. A start held high through done -> the second operation begins in the cycle done is high, and its done arrives 11 cycles later.
- Reset mid-operation: assert reset during the 4th ITER cycle -> next cycle busy=0, all outputs 0, no done pulse. A following 16'h0064 / 8'h0A -> quotient=8'h0A, remainder=8'h00.
- SIGNED_DIV_EN:
  - 16'hFF9C / 8'h07 (-100/7) -> quotient=8'hF2, remainder=8'hFE.
  - 16'h0080 / 8'h01 -> overflow=1.
  - 16'hFF80 / 8'h01 -> quotient=8'h80, no overflow.
